// File: rtl/sipo_frame_buffer.sv
// Serial-in/parallel-out frame collector: shifts signed samples into a DEPTH window and
// offers full (optionally overlapping) frames through a valid/ready output register.
module sipo_frame_buffer #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 32,
  parameter int HOP   = 32,
  parameter int CNT_W = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic signed [WIDTH-1:0]  d_in,
  input  logic                     flush,
  output logic [DEPTH*WIDTH-1:0]   frame_data,
  output logic                     frame_valid,
  input  logic                     frame_ready,
  output logic                     done,
  output logic                     overrun,
  output logic [CNT_W-1:0]         frame_cnt
);

  localparam int FILL_W = $clog2(DEPTH + 1);
  localparam int HOP_W  = (HOP > 1) ? $clog2(HOP + 1) : 1;

  typedef enum logic {FILL, STEADY} state_t;

  state_t                   state_q, state_d;
  logic [WIDTH-1:0]         win_q [DEPTH];
  logic [WIDTH-1:0]         win_d [DEPTH];
  logic [FILL_W-1:0]        fill_q, fill_d;
  logic [HOP_W-1:0]         hop_q, hop_d;
  logic [DEPTH*WIDTH-1:0]   frame_data_q, frame_data_d;
  logic                     frame_valid_q, frame_valid_d;
  logic                     done_q, done_d;
  logic                     overrun_q, overrun_d;
  logic [CNT_W-1:0]         frame_cnt_q, frame_cnt_d;
  logic [DEPTH*WIDTH-1:0]   win_flat;
  logic                     complete;

  always_comb begin
    win_d         = win_q;
    fill_d        = fill_q;
    hop_d         = hop_q;
    state_d       = state_q;
    complete      = 1'b0;
    frame_data_d  = frame_data_q;
    frame_valid_d = frame_valid_q;
    done_d        = 1'b0;
    overrun_d     = overrun_q;
    frame_cnt_d   = frame_cnt_q;
    win_flat      = '0;

    // Flush wins over a sample in the same cycle, which also suppresses any completion.
    if (flush) begin
      for (int i = 0; i < DEPTH; i++) win_d[i] = '0;
      fill_d  = '0;
      hop_d   = '0;
      state_d = FILL;
    end else if (in_valid) begin
      for (int i = 0; i < DEPTH - 1; i++) win_d[i] = win_q[i+1];
      win_d[DEPTH-1] = d_in;
      case (state_q)
        FILL: begin
          if (fill_q == FILL_W'(DEPTH - 1)) begin
            complete = 1'b1;
            state_d  = STEADY;
            hop_d    = '0;
            fill_d   = FILL_W'(DEPTH);
          end else begin
            fill_d = fill_q + 1'b1;
          end
        end
        STEADY: begin
          if (hop_q == HOP_W'(HOP - 1)) begin
            complete = 1'b1;
            hop_d    = '0;
          end else begin
            hop_d = hop_q + 1'b1;
          end
        end
        default: state_d = FILL;
      endcase
    end

    for (int k = 0; k < DEPTH; k++) win_flat[k*WIDTH +: WIDTH] = win_d[k];

    if (frame_valid_q && frame_ready) frame_valid_d = 1'b0;

    // A completed frame is only dropped when an unconsumed one is still held.
    if (complete) begin
      if (!frame_valid_q || frame_ready) begin
        frame_data_d  = win_flat;
        frame_valid_d = 1'b1;
        done_d        = 1'b1;
        frame_cnt_d   = frame_cnt_q + 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= FILL;
      for (int i = 0; i < DEPTH; i++) win_q[i] <= '0;
      fill_q        <= '0;
      hop_q         <= '0;
      frame_data_q  <= '0;
      frame_valid_q <= 1'b0;
      done_q        <= 1'b0;
      overrun_q     <= 1'b0;
      frame_cnt_q   <= '0;
    end else begin
      state_q       <= state_d;
      win_q         <= win_d;
      fill_q        <= fill_d;
      hop_q         <= hop_d;
      frame_data_q  <= frame_data_d;
      frame_valid_q <= frame_valid_d;
      done_q        <= done_d;
      overrun_q     <= overrun_d;
      frame_cnt_q   <= frame_cnt_d;
    end
  end

  assign frame_data  = frame_data_q;
  assign frame_valid = frame_valid_q;
  assign done        = done_q;
  assign overrun     = overrun_q;
  assign frame_cnt   = frame_cnt_q;

endmodule

// File: tb/tb_sipo_frame_buffer.sv
// Scoreboard bench for sipo_frame_buffer with DEPTH=4, HOP=2, WIDTH=16.
module tb_sipo_frame_buffer;

  localparam int WIDTH = 16;
  localparam int DEPTH = 4;
  localparam int HOP   = 2;
  localparam int CNT_W = 16;

  typedef struct packed {
    logic [DEPTH*WIDTH-1:0] data;
    logic [CNT_W-1:0]       cnt;
  } exp_t;

  logic                   clk = 1'b0;
  logic                   rst = 1'b1;
  logic                   in_valid = 1'b0;
  logic [WIDTH-1:0]       d_in = '0;
  logic                   flush = 1'b0;
  logic [DEPTH*WIDTH-1:0] frame_data;
  logic                   frame_valid;
  logic                   frame_ready = 1'b1;
  logic                   done;
  logic                   overrun;
  logic [CNT_W-1:0]       frame_cnt;

  int   checks = 0;
  int   errors = 0;
  exp_t exp_q [$];

  sipo_frame_buffer #(.WIDTH(WIDTH), .DEPTH(DEPTH), .HOP(HOP), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .d_in       (d_in),
    .flush      (flush),
    .frame_data (frame_data),
    .frame_valid(frame_valid),
    .frame_ready(frame_ready),
    .done       (done),
    .overrun    (overrun),
    .frame_cnt  (frame_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // slice 0 is the oldest sample
  function automatic logic [DEPTH*WIDTH-1:0] mk(input logic [15:0] s0, s1, s2, s3);
    return {s3, s2, s1, s0};
  endfunction

  task automatic expect_frame(input logic [DEPTH*WIDTH-1:0] f, input int c);
    exp_t e;
    e.data = f;
    e.cnt  = CNT_W'(c);
    exp_q.push_back(e);
  endtask

  task automatic send(input logic [15:0] v);
    in_valid = 1'b1;
    d_in     = v;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic do_reset();
    idle(2);
    rst = 1'b1; in_valid = 1'b0; flush = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    check("rst_valid",   64'(frame_valid), 64'd0);
    check("rst_done",    64'(done),        64'd0);
    check("rst_overrun", 64'(overrun),     64'd0);
    check("rst_cnt",     64'(frame_cnt),   64'd0);
    check("rst_data",    frame_data,       64'd0);
  endtask

  // Monitor: every done pulse must match the next expected frame.
  always @(negedge clk) begin
    if (!rst && done) begin
      if (exp_q.size() == 0) begin
        check("unexpected_done", 64'(frame_data), 64'd0);
        errors += (frame_data == 64'd0) ? 1 : 0;
        if (frame_data == 64'd0) $display("FAIL unexpected_done: done pulse with no frame expected");
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("frame_data", frame_data, e.data);
        check("frame_cnt",  64'(frame_cnt), 64'(e.cnt));
        check("frame_valid_on_done", 64'(frame_valid), 64'd1);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    // Basic fill
    do_reset();
    frame_ready = 1'b1;
    expect_frame(mk(1, 2, 3, 4), 1);
    for (int i = 1; i <= 4; i++) send(16'(i));
    check("t1_done_pulse", 64'(done), 64'd1);
    idle(1);
    check("t1_done_clear", 64'(done), 64'd0);

    // Overlapping frames with HOP=2
    do_reset();
    expect_frame(mk(1, 2, 3, 4), 1);
    expect_frame(mk(3, 4, 5, 6), 2);
    expect_frame(mk(5, 6, 7, 8), 3);
    for (int i = 1; i <= 8; i++) send(16'(i));
    idle(1);
    check("t2_cnt", 64'(frame_cnt), 64'd3);

    // Gaps in in_valid
    do_reset();
    expect_frame(mk(1, 2, 3, 4), 1);
    send(1); idle(1); send(2); idle(2); send(3); send(4);
    idle(2);
    check("t3_cnt", 64'(frame_cnt), 64'd1);

    // Backpressure and overrun
    do_reset();
    frame_ready = 1'b0;
    expect_frame(mk(1, 2, 3, 4), 1);
    for (int i = 1; i <= 4; i++) send(16'(i));
    check("t4_no_overrun_yet", 64'(overrun), 64'd0);
    send(5); send(6);
    check("t4_overrun",  64'(overrun),     64'd1);
    check("t4_held",     frame_data,       mk(1, 2, 3, 4));
    check("t4_cnt",      64'(frame_cnt),   64'd1);
    check("t4_valid",    64'(frame_valid), 64'd1);
    frame_ready = 1'b1;
    expect_frame(mk(5, 6, 7, 8), 2);
    send(7); send(8);
    check("t4_overrun_sticky", 64'(overrun), 64'd1);
    check("t4_cnt2", 64'(frame_cnt), 64'd2);

    // Consume and load in the same cycle
    do_reset();
    frame_ready = 1'b0;
    expect_frame(mk(1, 2, 3, 4), 1);
    for (int i = 1; i <= 4; i++) send(16'(i));
    send(5);
    frame_ready = 1'b1;
    expect_frame(mk(3, 4, 5, 6), 2);
    send(6);
    check("t5_valid",   64'(frame_valid), 64'd1);
    check("t5_overrun", 64'(overrun),     64'd0);
    check("t5_cnt",     64'(frame_cnt),   64'd2);

    // Flush discards partial window and a same-cycle completion
    do_reset();
    send(1); send(2);
    flush = 1'b1; in_valid = 1'b1; d_in = 16'd5;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    expect_frame(mk(9, 8, 7, 6), 1);
    send(9); send(8); send(7); send(6);
    send(10);
    flush = 1'b1; in_valid = 1'b1; d_in = 16'd11;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    idle(2);
    check("t6_cnt_after_flush", 64'(frame_cnt), 64'd1);

    // Reset mid-fill with a pending frame
    do_reset();
    frame_ready = 1'b0;
    expect_frame(mk(1, 2, 3, 4), 1);
    for (int i = 1; i <= 5; i++) send(16'(i));
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("t7_valid", 64'(frame_valid), 64'd0);
    check("t7_cnt",   64'(frame_cnt),   64'd0);
    check("t7_data",  frame_data,       64'd0);
    frame_ready = 1'b1;
    expect_frame(mk(7, 8, 9, 10), 1);
    send(7); send(8); send(9);
    check("t7_no_early_frame", 64'(frame_valid), 64'd0);
    send(10);
    check("t7_cnt2", 64'(frame_cnt), 64'd1);

    // Signed extremes stored verbatim
    do_reset();
    expect_frame(mk(16'h8000, 16'h7FFF, 16'hFFFF, 16'h0001), 1);
    send(16'h8000); send(16'h7FFF); send(16'hFFFF); send(16'h0001);

    idle(3);
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
